r2p_mult_seq: RTL and testbench

Digit-serial radix-2 online (MSDF) multiplier controller.
- Accepts two WIDTH-digit signed-digit operands in parallel, then runs the online recurrence one iteration per cycle with online delay δ=3.
- Streams product digits most-significant first under a valid/ready handshake, and also assembles the parallel product word.
- Sits beside the unrolled combinational multiplier array as its area-cheap, time-multiplexed alternative for throughput-tolerant paths.

---
 rtl/r2p_mult_seq_if.sv | 42 ++++
 rtl/r2p_mult_seq.sv | 219 +++++++++++++++++++++
 tb/tb_r2p_mult_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/r2p_mult_seq_if.sv
// -----------------------------------------------------------------------------
// r2p_mult_seq_if
//   Handshake/data bundle of the digit-serial online multiplier.
//   master : load requester and product consumer (drives start, operands,
//            out_ready).
//   slave  : the multiplier controller (drives ready, the product digit
//            stream and the assembled product word).
//
//   start      operand load request, honoured only while ready=1
//   x_in/y_in  WIDTH signed digits each, MSD in the top bit pair
//   ready      controller idle
//   p_digit    product digit (01=+1, 11=-1, 00=0), qualified by p_valid
//   p_valid    p_digit valid
//   p_last     last product digit (qualified by p_valid)
//   out_ready  consumer accepts p_digit this cycle
//   p_out      assembled product, first digit in the top bit pair
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
interface r2p_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [2*WIDTH-1:0]   x_in;
    logic [2*WIDTH-1:0]   y_in;
    logic                 ready;
    logic [1:0]           p_digit;
    logic                 p_valid;
    logic                 p_last;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p_out;
    logic                 done;

    modport master (
        output start, x_in, y_in, out_ready,
        input  ready, p_digit, p_valid, p_last, p_out, done
    );

    modport slave (
        input  start, x_in, y_in, out_ready,
        output ready, p_digit, p_valid, p_last, p_out, done
    );
endinterface

// File: rtl/r2p_mult_seq.sv
// -----------------------------------------------------------------------------
// r2p_mult_seq
//   Radix-2 online (MSDF) multiplier, online delay 3. Both operands are loaded
//   in parallel, then one recurrence iteration runs per cycle: three warm-up
//   iterations that emit nothing, followed by WIDTH iterations that each emit
//   one product digit under a valid/ready handshake. The digits are also
//   shifted into a parallel product word.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    r2p_mult_seq_if.slave (start/x_in/y_in in, digit stream and
//            p_out/done out, out_ready back-pressure in)
//
//   Fixed-point formats:
//     operand prefixes xp/yp : WIDTH+2 bit two's complement, LSB = 2^-WIDTH
//     residual w             : 3 integer + 2*WIDTH+3 fraction bits
// -----------------------------------------------------------------------------
module r2p_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    r2p_mult_seq_if.slave  bus
);
    localparam int FW = 2*WIDTH + 3;          // residual fraction bits
    localparam int RW = FW + 3;               // residual total width
    localparam int PW = WIDTH + 2;            // prefix width
    localparam int TW = PW + 1;               // width of the summed product terms
    localparam int CW = $clog2(WIDTH + 1);    // iteration / digit counter

    localparam logic signed [RW-1:0] W_ONE = {3'b001, {FW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;

    // Registered outputs
    logic                ready_r;
    logic [1:0]          p_digit_r;
    logic                p_valid_r;
    logic                p_last_r;
    logic [2*WIDTH-1:0]  p_out_r;
    logic                done_r;

    // Datapath state
    logic [2*WIDTH-1:0]  xs;      // remaining multiplicand digits, next at MSB
    logic [2*WIDTH-1:0]  ys;      // remaining multiplier digits, next at MSB
    logic signed [PW-1:0] xp;     // X[j]
    logic signed [PW-1:0] yp;     // Y[j]
    logic [WIDTH-1:0]    wt;      // weight of the digit being consumed, 2^-(j+4)
    logic signed [RW-1:0] w;      // residual

    // Combinational iteration results
    logic                 x_pos, x_neg, y_pos, y_neg;
    logic signed [PW-1:0] wt_s;
    logic signed [PW-1:0] x_nxt, y_nxt;
    logic signed [TW-1:0] term;
    logic signed [RW-1:0] v, w_nxt;
    logic signed [4:0]    vh;
    logic                 p_pos, p_neg;
    logic [1:0]           p_code;
    logic                 load, adv, step;

    // 2'b10 decodes to neither +1 nor -1, so it is consumed as a zero digit.
    assign x_pos = (xs[2*WIDTH-1 -: 2] == 2'b01);
    assign x_neg = (xs[2*WIDTH-1 -: 2] == 2'b11);
    assign y_pos = (ys[2*WIDTH-1 -: 2] == 2'b01);
    assign y_neg = (ys[2*WIDTH-1 -: 2] == 2'b11);
    assign wt_s  = signed'({2'b00, wt});

    // A digit leaves the output register when it is accepted or when nothing
    // valid is sitting there; everything else holds under back-pressure.
    assign load = (state == S_IDLE) && bus.start;
    assign adv  = !p_valid_r || bus.out_ready;
    assign step = (state == S_PRE) || ((state == S_RUN) && adv && !p_last_r);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        x_nxt  = xp;
        y_nxt  = yp;
        term   = '0;
        p_pos  = 1'b0;
        p_neg  = 1'b0;
        p_code = 2'b00;

        if (x_pos)      x_nxt = xp + wt_s;
        else if (x_neg) x_nxt = xp - wt_s;
        if (y_pos)      y_nxt = yp + wt_s;
        else if (y_neg) y_nxt = yp - wt_s;

        // X[j]*y_{j+4} + Y[j+1]*x_{j+4}, LSB = 2^-WIDTH
        if (y_pos)      term = term + TW'(xp);
        else if (y_neg) term = term - TW'(xp);
        if (x_pos)      term = term + TW'(y_nxt);
        else if (x_neg) term = term - TW'(y_nxt);

        // Shifting by WIDTH rescales 2^-WIDTH to the residual LSB 2^-(2W+3),
        // which also applies the 2^-3 online-delay factor.
        v  = (w <<< 1) + (RW'(term) <<< WIDTH);

        // Floor to two fraction bits: the top five residual bits in quarters.
        vh = v[RW-1 -: 5];

        if (state == S_RUN) begin
            p_pos = (vh >= 5'sd2);
            p_neg = (vh <= -5'sd3);
        end

        w_nxt = v;
        if (p_pos) begin
            w_nxt  = v - W_ONE;
            p_code = 2'b01;
        end else if (p_neg) begin
            w_nxt  = v + W_ONE;
            p_code = 2'b11;
        end
    end

    // Recurrence state: loaded on an accepted start, advanced once per iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            xs <= '0;
            ys <= '0;
            xp <= '0;
            yp <= '0;
            wt <= '0;
            w  <= '0;
        end else if (load) begin
            xs <= bus.x_in;
            ys <= bus.y_in;
            xp <= '0;
            yp <= '0;
            wt <= {1'b1, {(WIDTH-1){1'b0}}};
            w  <= '0;
        end else if (step) begin
            xs <= {xs[2*WIDTH-3:0], 2'b00};
            ys <= {ys[2*WIDTH-3:0], 2'b00};
            xp <= x_nxt;
            yp <= y_nxt;
            wt <= wt >> 1;
            w  <= w_nxt;
        end
    end

    // Controller FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ready_r   <= 1'b1;
            p_digit_r <= 2'b00;
            p_valid_r <= 1'b0;
            p_last_r  <= 1'b0;
            p_out_r   <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ready_r <= 1'b0;
                        cnt     <= '0;
                        p_out_r <= '0;
                        state   <= S_PRE;
                    end
                end

                S_PRE: begin
                    if (cnt == CW'(2)) begin
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (adv) begin
                        if (p_last_r) begin
                            // Final digit taken by the consumer.
                            p_valid_r <= 1'b0;
                            p_last_r  <= 1'b0;
                            p_digit_r <= 2'b00;
                            done_r    <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            p_digit_r <= p_code;
                            p_valid_r <= 1'b1;
                            p_last_r  <= (cnt == CW'(WIDTH-1));
                            p_out_r   <= {p_out_r[2*WIDTH-3:0], p_code};
                            cnt       <= cnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    ready_r <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.p_digit = p_digit_r;
    assign bus.p_valid = p_valid_r;
    assign bus.p_last  = p_last_r;
    assign bus.p_out   = p_out_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_r2p_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_r2p_mult_seq
//   Directed table of operand pairs with hand-derived product digit strings,
//   followed by hand-written stall, busy-start and mid-run reset sequences and
//   a randomized sweep checked against the exact product within the accuracy
//   bound 2^-(WIDTH-1).
// -----------------------------------------------------------------------------
module tb_r2p_mult_seq;
    localparam int W  = 4;
    localparam int DW = 2*W;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    r2p_mult_seq_if #(.WIDTH(W)) bus ();

    r2p_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] p;   // expected digit string, first digit in the top pair
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int idx, input int act, input int lim);
        n_vec++;
        if (act > lim) begin
            n_miss++;
            $display("FAIL %s[%0d]: got %0d, limit %0d", name, idx, act, lim);
        end
    endtask

    // Digit string value scaled by 2^W.
    function automatic int digits_val(input logic [DW-1:0] d);
        int s;
        logic [1:0] pr;
        s = 0;
        for (int i = 0; i < W; i++) begin
            pr = d[DW-1-2*i -: 2];
            if (pr == 2'b01)      s = s + (1 << (W-1-i));
            else if (pr == 2'b11) s = s - (1 << (W-1-i));
        end
        return s;
    endfunction

    function automatic logic [1:0] rand_digit();
        case ($urandom_range(0, 2))
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // One complete operation, entered at a negedge with ready=1.
    // mode 0: out_ready=1; mode 1: random out_ready; mode 2: 5-cycle stall on
    // the third digit. busy=1 pulses start while the operation is in flight.
    // Edge numbers count rising edges, with edge 0 sampling start.
    task automatic run_op(input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input int mode, input bit busy,
                          output logic [DW-1:0] digits, output logic [DW-1:0] pout,
                          output int first_valid, output int done_edge,
                          output int ready_edge, output int nd, output bit bad);
        int stall_left;
        logic [1:0] held;
        bit stalling;
        digits      = '0;
        pout        = '0;
        first_valid = -1;
        done_edge   = -1;
        ready_edge  = -1;
        nd          = 0;
        bad         = 1'b0;
        stall_left  = 5;
        stalling    = 1'b0;
        held        = 2'b00;
        bus.x_in    = x;
        bus.y_in    = y;
        bus.start   = 1'b1;
        for (int e = 0; e < 400; e++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (busy && (e == 2 || e == 5)) begin
                bus.start = 1'b1;
                bus.x_in  = ~x;
                bus.y_in  = 8'h55;
            end
            if (bus.p_digit == 2'b10) bad = 1'b1;
            if (bus.p_last && !bus.p_valid) bad = 1'b1;
            if (bus.p_valid) begin
                if (first_valid < 0) first_valid = e;
                if (bus.p_last !== (nd == W-1)) bad = 1'b1;
                if (stalling && bus.p_digit !== held) bad = 1'b1;
                case (mode)
                    0:       bus.out_ready = 1'b1;
                    1:       bus.out_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (nd == 2 && stall_left > 0) begin
                            bus.out_ready = 1'b0;
                            if (!stalling) held = bus.p_digit;
                            stalling   = 1'b1;
                            stall_left = stall_left - 1;
                        end else begin
                            bus.out_ready = 1'b1;
                        end
                    end
                endcase
                if (bus.out_ready) begin
                    digits   = {digits[DW-3:0], bus.p_digit};
                    nd       = nd + 1;
                    stalling = 1'b0;
                end
            end else begin
                bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bus.done) begin
                done_edge = e;
                pout      = bus.p_out;
                if (busy) bus.start = 1'b1;   // must be ignored while done=1
            end
            if (bus.ready) begin
                ready_edge = e;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] dig, pout;
        int fv, de, re, nd, err;
        bit bad;

        vecs[0] = '{8'b01_00_00_00, 8'b01_00_00_00, 8'b01_11_00_00}; // 1/2*1/2 = 1/4
        vecs[1] = '{8'b01_00_00_00, 8'b11_00_00_00, 8'b00_11_00_00}; // 1/2*-1/2 = -1/4
        vecs[2] = '{8'b01_01_01_01, 8'b01_01_01_01, 8'b01_01_01_00}; // 15/16^2 -> 7/8
        vecs[3] = '{8'b01_10_10_00, 8'b01_00_10_00, 8'b01_11_00_00}; // 10 digits read as 0
        vecs[4] = '{8'b11_00_00_00, 8'b11_00_00_00, 8'b01_11_00_00}; // -1/2*-1/2 = 1/4
        vecs[5] = '{8'b01_11_00_00, 8'b01_00_00_00, 8'b00_01_11_00}; // 1/4*1/2 = 1/8
        vecs[6] = '{8'b00_00_00_01, 8'b01_01_01_01, 8'b00_00_00_01}; // 1/16*15/16 -> 1/16
        vecs[7] = '{8'b00_00_00_00, 8'b01_01_01_01, 8'b00_00_00_00}; // zero

        bus.start     = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready",   0, 64'(bus.ready),   64'd1);
        check("rst_p_valid", 0, 64'(bus.p_valid), 64'd0);
        check("rst_p_last",  0, 64'(bus.p_last),  64'd0);
        check("rst_done",    0, 64'(bus.done),    64'd0);
        check("rst_p_digit", 0, 64'(bus.p_digit), 64'd0);
        check("rst_p_out",   0, 64'(bus.p_out),   64'd0);

        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, no back-pressure.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].y, 0, 1'b0, dig, pout, fv, de, re, nd, bad);
            check("p_out",       i, 64'(pout), 64'(vecs[i].p));
            check("stream",      i, 64'(dig),  64'(vecs[i].p));
            check("first_valid", i, 64'(fv),   64'(4));
            check("done_edge",   i, 64'(de),   64'(W+4));
            check("ready_edge",  i, 64'(re),   64'(W+5));
            check("n_digits",    i, 64'(nd),   64'(W));
            check("protocol",    i, 64'(bad),  64'd0);
        end

        // Five-cycle stall on the third digit delays done by exactly five.
        run_op(vecs[2].x, vecs[2].y, 2, 1'b0, dig, pout, fv, de, re, nd, bad);
        check("stall_p_out",  0, 64'(pout), 64'(vecs[2].p));
        check("stall_stream", 0, 64'(dig),  64'(vecs[2].p));
        check("stall_done",   0, 64'(de),   64'(W+9));
        check("stall_ready",  0, 64'(re),   64'(W+10));
        check("stall_proto",  0, 64'(bad),  64'd0);

        // start pulses while busy and during done are ignored.
        run_op(vecs[0].x, vecs[0].y, 0, 1'b1, dig, pout, fv, de, re, nd, bad);
        check("busy_p_out", 0, 64'(pout), 64'(vecs[0].p));
        check("busy_done",  0, 64'(de),   64'(W+4));
        check("busy_ready", 0, 64'(re),   64'(W+5));

        // Start right in the first ready cycle after done is accepted.
        run_op(vecs[5].x, vecs[5].y, 0, 1'b0, dig, pout, fv, de, re, nd, bad);
        check("b2b_p_out",       0, 64'(pout), 64'(vecs[5].p));
        check("b2b_first_valid", 0, 64'(fv),   64'(4));

        // Asynchronous reset in the middle of RUN.
        bus.x_in      = vecs[0].x;
        bus.y_in      = vecs[0].y;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("prerst_valid", 0, 64'(bus.p_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready",   0, 64'(bus.ready),   64'd1);
        check("arst_p_valid", 0, 64'(bus.p_valid), 64'd0);
        check("arst_p_last",  0, 64'(bus.p_last),  64'd0);
        check("arst_done",    0, 64'(bus.done),    64'd0);
        check("arst_p_digit", 0, 64'(bus.p_digit), 64'd0);
        check("arst_p_out",   0, 64'(bus.p_out),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(vecs[2].x, vecs[2].y, 0, 1'b0, dig, pout, fv, de, re, nd, bad);
        check("postrst_p_out", 0, 64'(pout), 64'(vecs[2].p));
        check("postrst_done",  0, 64'(de),   64'(W+4));

        // Random legal operands with random back-pressure.
        for (int r = 0; r < 1000; r++) begin
            logic [DW-1:0] rx, ry;
            for (int k = 0; k < W; k++) begin
                rx[2*k +: 2] = rand_digit();
                ry[2*k +: 2] = rand_digit();
            end
            run_op(rx, ry, 1, 1'b0, dig, pout, fv, de, re, nd, bad);
            err = digits_val(rx) * digits_val(ry) - digits_val(dig) * (1 << W);
            if (err < 0) err = -err;
            check_le("rand_bound", r, err, 1 << (W+1));
            check("rand_p_out",    r, 64'(pout), 64'(dig));
            check("rand_n_digits", r, 64'(nd),   64'(W));
            check("rand_protocol", r, 64'(bad),  64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
